// File: rtl/mem_banked.sv
// Banked byte-writable RAM with single-cycle access, write-first read data and
// an optional post-reset zero-fill that sweeps one row of every bank per cycle.
module mem_banked #(
    parameter int DW           = 32,
    parameter int AW           = 12,
    parameter int BANK_BITS    = 3,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   adr,
    input  logic [DW-1:0]   dat_i,
    input  logic [DW/8-1:0] sel,
    input  logic            we,
    input  logic            en,
    output logic [DW-1:0]   dat_o,
    output logic            ack,
    output logic            busy
);

    localparam int LANES = DW / 8;
    localparam int BANKS = 2 ** BANK_BITS;
    localparam int RW    = AW - BANK_BITS;
    localparam int ROWS  = 2 ** RW;
    localparam logic [RW-1:0] LAST_ROW = '1;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    localparam state_e RESET_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    state_e               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [7:0]           mem_q [BANKS][ROWS][LANES];
    logic [DW-1:0]        rd_q  [BANKS];
    logic [BANK_BITS-1:0] bank_q;
    logic                 ack_q;

    logic [BANK_BITS-1:0] reqBank;
    logic [RW-1:0]        reqRow;
    logic                 accept;
    logic [BANKS-1:0]     bankEn;
    logic [DW-1:0]        merged;

    assign reqBank = adr[AW-1 -: BANK_BITS];
    assign reqRow  = adr[RW-1:0];
    assign accept  = en && (state_q == ST_READY) && !rst;

    always_comb begin
        bankEn = '0;
        for (int b = 0; b < BANKS; b++) begin
            bankEn[b] = accept && (reqBank == BANK_BITS'(b));
        end
    end

    // Write-first view of the addressed word: new bytes where written, stored bytes elsewhere.
    always_comb begin
        merged = '0;
        for (int k = 0; k < LANES; k++) begin
            merged[8*k +: 8] = (we && sel[k]) ? dat_i[8*k +: 8] : mem_q[reqBank][reqRow][k];
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            ST_CLEAR: begin
                row_d = row_q + 1'b1;
                if (row_q == LAST_ROW) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                row_d = '0;
            end
            default: begin
                state_d = RESET_STATE;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Storage is deliberately outside reset so contents survive rst when no clear is configured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                for (int b = 0; b < BANKS; b++) begin
                    for (int k = 0; k < LANES; k++) begin
                        mem_q[b][row_q][k] <= 8'h00;
                    end
                end
            end else begin
                for (int b = 0; b < BANKS; b++) begin
                    if (bankEn[b] && we) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (sel[k]) begin
                                mem_q[b][reqRow][k] <= dat_i[8*k +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                rd_q[b] <= '0;
            end
            bank_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                bank_q <= reqBank;
            end
            for (int b = 0; b < BANKS; b++) begin
                if (bankEn[b]) begin
                    rd_q[b] <= merged;
                end
            end
        end
    end

    // The output mux follows the bank captured at acceptance, not the live address.
    assign dat_o = rd_q[bank_q];
    assign ack   = ack_q;
    assign busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_banked.sv
// Scoreboard bench for mem_banked: one instance with post-reset clear, one without,
// both checked every cycle against a word-level reference memory.
module tb_mem_banked;

    localparam int ROWS = 512;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rstS  [2];
    logic        enS   [2];
    logic        weS   [2];
    logic [11:0] adrS  [2];
    logic [31:0] datS  [2];
    logic [3:0]  selS  [2];
    logic [31:0] doutS [2];
    logic        ackS  [2];
    logic        busyS [2];

    logic [31:0] modelMem  [2][4096];
    int          modelBusy [2];
    int          rstCyc    [2];
    bit          checking  [2];
    logic [31:0] lastExp   [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cycleCnt;
    int          tests;
    int          errors;
    logic        expAck;
    exp_t        front;
    int          n;

    mem_banked #(.DW(32), .AW(12), .BANK_BITS(3), .CLEAR_ON_RST(1)) dut (
        .clk(clk), .rst(rstS[0]), .adr(adrS[0]), .dat_i(datS[0]), .sel(selS[0]),
        .we(weS[0]), .en(enS[0]), .dat_o(doutS[0]), .ack(ackS[0]), .busy(busyS[0])
    );

    mem_banked #(.DW(32), .AW(12), .BANK_BITS(3), .CLEAR_ON_RST(0)) dutNoClear (
        .clk(clk), .rst(rstS[1]), .adr(adrS[1]), .dat_i(datS[1]), .sel(selS[1]),
        .we(weS[1]), .en(enS[1]), .dat_o(doutS[1]), .ack(ackS[1]), .busy(busyS[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cycleCnt, act, exp);
        end
    endtask

    function automatic int qSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qFront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qPop(input int d);
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endfunction

    function automatic void qPush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    // Drive one cycle of inputs on DUT d (the other DUT idles) and predict its response.
    task automatic applyStimulus(input int d, input logic r, input logic e, input logic w,
                                 input logic [11:0] a, input logic [31:0] dt, input logic [3:0] s);
        int          other;
        logic [31:0] word;
        exp_t        ent;
        @(negedge clk);
        other        = 1 - d;
        rstS[other]  = 1'b0;
        enS[other]   = 1'b0;
        rstS[d]      = r;
        enS[d]       = e;
        weS[d]       = w;
        adrS[d]      = a;
        datS[d]      = dt;
        selS[d]      = s;
        if (r && d == 0) begin
            for (int i = 0; i < 4096; i++) modelMem[0][i] = 32'h0;
        end
        if (e && !r && modelBusy[d] == 0) begin
            word = modelMem[d][a];
            for (int k = 0; k < 4; k++) begin
                if (w && s[k]) word[8*k +: 8] = dt[8*k +: 8];
            end
            if (w) modelMem[d][a] = word;
            ent.data = word;
            ent.cyc  = cycleCnt;
            qPush(d, ent);
        end
    endtask

    task automatic runClear(input int d, input bit traffic, input int limit, output int cnt);
        cnt = 0;
        for (int i = 0; i < limit; i++) begin
            if (traffic)
                applyStimulus(d, 1'b0, 1'b1, 1'($urandom), {3'($urandom), 9'($urandom_range(0, 15))},
                              $urandom, 4'($urandom));
            else
                applyStimulus(d, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
            if (busyS[d] === 1'b1) cnt++;
            else break;
        end
    endtask

    // Reference timing: a clearing instance is unavailable for ROWS cycles after its reset edge.
    always @(posedge clk) begin
        cycleCnt++;
        for (int d = 0; d < 2; d++) begin
            if (rstS[d]) begin
                checking[d]  = 1'b1;
                modelBusy[d] = (d == 0) ? ROWS : 0;
                rstCyc[d]    = cycleCnt;
            end else if (modelBusy[d] > 0) begin
                modelBusy[d]--;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (checking[d]) begin
                if (rstCyc[d] == cycleCnt) lastExp[d] = 32'h0;
                expAck = (qSize(d) > 0) && (qFront(d).cyc + 1 == cycleCnt);
                checkOutput("ack", d, {31'b0, ackS[d]}, {31'b0, expAck});
                checkOutput("busy", d, {31'b0, busyS[d]}, {31'b0, modelBusy[d] > 0});
                if (expAck) begin
                    front = qFront(d);
                    qPop(d);
                    checkOutput("ackData", d, doutS[d], front.data);
                    lastExp[d] = front.data;
                end else begin
                    checkOutput("holdData", d, doutS[d], lastExp[d]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk      = 1'b0;
        cycleCnt = 0;
        tests    = 0;
        errors   = 0;
        for (int d = 0; d < 2; d++) begin
            rstS[d] = 1'b1; enS[d] = 1'b0; weS[d] = 1'b0; adrS[d] = '0; datS[d] = '0; selS[d] = '0;
            modelBusy[d] = 0; rstCyc[d] = -1; checking[d] = 1'b0; lastExp[d] = '0;
        end

        // Reset and full clear, then a read of cleared memory.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        runClear(0, 1'b0, 2000, n);
        checkOutput("clearCycles", 0, n, 32'd512);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 12'hABC, 32'h0, 4'h0);

        // Byte-lane merge, then a write with no lanes enabled.
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 12'h805, 32'h11223344, 4'hF);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 12'h805, 32'hAABBCCDD, 4'b0101);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 12'h805, 32'h0, 4'h0);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 12'h805, 32'hFFFFFFFF, 4'h0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 12'h805, 32'h0, 4'h0);

        // Alternating banks 0 and 7 on the same row, back to back; adr moves on every ack.
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 12'h02A, 32'h0B0B0000, 4'hF);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 12'hE2A, 32'h7B7B7777, 4'hF);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 12'h02A : 12'hE2A, 32'h0, 4'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h555, 32'h0, 4'h0);

        for (int i = 0; i < 300; i++)
            applyStimulus(0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                          {3'($urandom), (i % 4 == 0) ? 9'd511 : 9'($urandom_range(0, 5))},
                          $urandom, 4'($urandom));

        // Requests during clear are dropped; reset mid-clear restarts the sweep.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        runClear(0, 1'b1, 100, n);
        checkOutput("partialClear", 0, n, 32'd100);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        runClear(0, 1'b1, 2000, n);
        checkOutput("restartClear", 0, n, 32'd512);
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1'b0, 1'b1, 1'b0, {3'($urandom), 9'(i)}, 32'h0, 4'h0);

        // No-clear instance: contents survive reset; reset beats a simultaneous write.
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 12'h001, 32'hDEADBEEF, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 12'h010, 32'h12345678, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 12'h010, 32'hFFFFFFFF, 4'hF);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 12'h010, 32'h9900AA00, 4'b1010);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);

        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/mem_banked.md
MEM_BANKED -- requirements
Module: mem_banked

Interface
REQ-001 Parameter DW, default 32: data width in bits; a multiple of 8; lanes = DW/8.
REQ-002 Parameter AW, default 12: word-address width; total depth = 2^AW words.
REQ-003 Parameter BANK_BITS, default 3: banks = 2^BANK_BITS; each bank is 2^(AW-BANK_BITS) words deep; BANK_BITS < AW.
REQ-004 Parameter CLEAR_ON_RST, default 1: 1 = zero the entire memory after reset; 0 = no clear.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 adr  input  AW  word address; bank = adr[AW-1 -: BANK_BITS], row = remaining low bits.
REQ-008 dat_i  input  DW  write data.
REQ-009 sel  input  DW/8  byte-lane write enables; lane k = dat_i[8k+7:8k].
REQ-010 we  input  1  1 = write, 0 = read; sampled only with en.
REQ-011 en  input  1  request strobe; one request per cycle while high.
REQ-012 dat_o  output  DW  read data / write-through data.
REQ-013 ack  output  1  one-cycle pulse, one per accepted request.
REQ-014 busy  output  1  high while the clear sequence runs; requests are not accepted.

Function
REQ-015 Storage: banks × rows × lanes byte cells; only the addressed bank is enabled per access.
REQ-016 FSM states: CLEAR, READY; reset enters CLEAR if CLEAR_ON_RST=1, else READY.
REQ-017 CLEAR: row counter runs 0 to 2^(AW-BANK_BITS)-1, one row per cycle, written with zeros in all banks and lanes simultaneously; busy=1; after the last row, next state is READY.
REQ-018 Clear duration: busy high for exactly 2^(AW-BANK_BITS) cycles after the reset-deassert edge.
REQ-019 Accept: a request is accepted on an edge where en=1, busy=0 and rst=0.
REQ-020 Requests with en=1 while busy=1 are dropped: no ack, no write, no queuing.
REQ-021 Read latency: ack=1 and dat_o valid in the cycle after acceptance (1-cycle latency).
REQ-022 The output bank mux uses the bank index registered at acceptance, not the live adr; changing adr in the ack cycle does not affect dat_o.
REQ-023 Write: lanes with sel[k]=1 are updated; lanes with sel[k]=0 retain their old contents.
REQ-024 Write-first: on a write ack, dat_o = new data on written lanes and stored data on unwritten lanes.
REQ-025 A write with sel=0 is still acked; memory is unchanged and dat_o = the stored word.
REQ-026 Back-to-back: with en held high, one ack per cycle; a read following a write to the same address returns the written data.
REQ-027 dat_o holds its last value when ack=0; it changes only on an ack cycle or on reset.
REQ-028 Addressing covers all 2^AW words; the bank field wraps naturally and no address is illegal.
REQ-029 Reset and request in the same cycle: reset wins; the request is dropped, with no write and no ack.

Reset
REQ-030 Synchronous active-high reset: dat_o=0, ack=0, busy=1 in the next cycle if CLEAR_ON_RST=1, else busy=0; row counter=0; FSM per REQ-016.
REQ-031 Memory contents are not altered by rst itself; with CLEAR_ON_RST=0 they survive reset.
REQ-032 Reset asserted mid-clear restarts the clear from row 0.
REQ-033 Reset asserted mid-access cancels the pending ack.

Verification
REQ-034 Reset with DW=32, AW=12, BANK_BITS=3, CLEAR_ON_RST=1 -> busy high for exactly 512 cycles; a read of 0xABC then returns 0x00000000.
REQ-035 Write 0x11223344 to adr 0x805 with sel=4'hF, then write 0xAABBCCDD with sel=4'b0101, then read -> read ack returns 0x11BB33DD; each write ack shows the merged word.
REQ-036 en held high for 8 cycles, alternating banks 0 and 7 at the same row -> 8 acks on consecutive cycles; each dat_o matches its own bank, and adr is changed in the ack cycle to prove the registered mux.
REQ-037 en=1 during the clear -> no ack, memory remains zero; reset after 100 clear cycles -> busy high for a further 512 cycles.
REQ-038 CLEAR_ON_RST=0: write 0xDEADBEEF to 0x001, pulse rst, read 0x001 -> busy never high, dat_o=0 after reset, read returns 0xDEADBEEF.
REQ-039 rst and en=1, we=1 in the same cycle -> no ack, and a later read shows the location unchanged.
